// File: rtl/mem_core_wr_pkg.sv
// Shared types and default widths for the memory_core write driver.
package mem_core_wr_pkg;

    localparam int unsigned MC_DATA_W  = 16;
    localparam int unsigned MC_DEPTH_W = 16;
    localparam int unsigned MC_CNT_W   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } wr_state_t;

endpackage

// File: rtl/mem_core_credit_ctr.sv
// Up/down count of words written to the core but not yet read back.
// Decrement saturates at zero; "below" says another word may be written.
module mem_core_credit_ctr
    import mem_core_wr_pkg::*;
#(
    parameter int unsigned DEPTH_W = MC_DEPTH_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    input  logic               inc,
    input  logic               dec,
    input  logic [DEPTH_W-1:0] depth,
    output logic [DEPTH_W:0]   count,
    output logic               below
);

    logic [DEPTH_W:0] r_count;
    logic             w_dec_eff;

    // A read with nothing outstanding is dropped so the count cannot underflow.
    always_comb begin
        w_dec_eff = dec & (r_count != '0);
    end

    // Counter update; simultaneous inc and effective dec cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (en) begin
            if (clr) begin
                r_count <= '0;
            end else if (inc && !w_dec_eff) begin
                r_count <= r_count + (DEPTH_W+1)'(1);
            end else if (!inc && w_dec_eff) begin
                r_count <= r_count - (DEPTH_W+1)'(1);
            end
        end
    end

    // Outputs: current count and credit-available compare against zero-extended depth.
    always_comb begin
        count = r_count;
        below = r_count < {1'b0, depth};
    end

endmodule

// File: rtl/mem_core_write_driver.sv
// Write-side stream driver for memory_core: forwards source words to the
// core write port while keeping unread words at or below depth.
module mem_core_write_driver
    import mem_core_wr_pkg::*;
#(
    parameter int unsigned DATA_W  = MC_DATA_W,
    parameter int unsigned DEPTH_W = MC_DEPTH_W,
    parameter int unsigned CNT_W   = MC_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic               flush,
    input  logic [DEPTH_W-1:0] depth,
    input  logic [CNT_W-1:0]   num_words,
    input  logic               start,
    input  logic               src_valid,
    input  logic [DATA_W-1:0]  src_data,
    output logic               src_ready,
    output logic               wen_out,
    output logic [DATA_W-1:0]  data_out,
    input  logic               core_ren,
    input  logic               core_valid,
    output logic [DEPTH_W:0]   outstanding,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    wr_state_t          r_state;
    wr_state_t          w_next;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_wen;
    logic [DATA_W-1:0]  r_data;
    logic               r_cfg_err;

    logic [DEPTH_W:0]   w_outstanding;
    logic               w_below;
    logic               w_ready;
    logic               w_accept;
    logic               w_rd;
    logic               w_last;
    logic               w_idle_start;

    // Handshake qualifiers; flush wins over an accept in the same cycle.
    always_comb begin
        w_ready      = clk_en & (r_state == STREAM) & w_below;
        w_accept     = w_ready & src_valid & ~flush;
        w_rd         = clk_en & core_ren & core_valid;
        w_last       = w_accept & (r_remaining == CNT_W'(1));
        w_idle_start = (r_state == IDLE) & start;
    end

    mem_core_credit_ctr #(
        .DEPTH_W (DEPTH_W)
    ) u_credit (
        .clk   (clk),
        .reset (reset),
        .en    (clk_en),
        .clr   (flush),
        .inc   (w_accept),
        .dec   (w_rd),
        .depth (depth),
        .count (w_outstanding),
        .below (w_below)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else if (clk_en) begin
            r_state <= flush ? IDLE : w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start && depth != '0) begin
                    w_next = (num_words == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (w_last) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_outstanding == '0) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        src_ready = w_ready;
        busy      = (r_state != IDLE);
        done      = (r_state == DONE);
    end

    // Words still to accept in this transfer; only decremented on accept, so never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_remaining <= '0;
        end else if (clk_en) begin
            if (flush) begin
                r_remaining <= '0;
            end else if (w_idle_start && depth != '0) begin
                r_remaining <= num_words;
            end else if (w_accept) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end
        end
    end

    // Registered core write port and configuration-error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wen     <= 1'b0;
            r_data    <= '0;
            r_cfg_err <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                r_wen     <= 1'b0;
                r_cfg_err <= 1'b0;
            end else begin
                r_wen     <= w_accept;
                r_cfg_err <= w_idle_start & (depth == '0);
                if (w_accept) begin
                    r_data <= src_data;
                end
            end
        end
    end

    // Drive registered outputs.
    always_comb begin
        wen_out     = r_wen;
        data_out    = r_data;
        cfg_err     = r_cfg_err;
        outstanding = w_outstanding;
    end

endmodule

// File: tb/tb_mem_core_write_driver.sv
// Self-checking bench for mem_core_write_driver: directed scenarios followed
// by randomized transfers, checked against a cycle-level behavioural model.
module tb_mem_core_write_driver;

    localparam int unsigned DW  = 16;
    localparam int unsigned DPW = 16;
    localparam int unsigned CW  = 32;

    logic           clk;
    logic           reset;
    logic           clk_en;
    logic           flush;
    logic [DPW-1:0] depth;
    logic [CW-1:0]  num_words;
    logic           start;
    logic           src_valid;
    logic [DW-1:0]  src_data;
    logic           src_ready;
    logic           wen_out;
    logic [DW-1:0]  data_out;
    logic           core_ren;
    logic           core_valid;
    logic [DPW:0]   outstanding;
    logic           busy;
    logic           done;
    logic           cfg_err;

    mem_core_write_driver #(
        .DATA_W  (DW),
        .DEPTH_W (DPW),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .flush       (flush),
        .depth       (depth),
        .num_words   (num_words),
        .start       (start),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .wen_out     (wen_out),
        .data_out    (data_out),
        .core_ren    (core_ren),
        .core_valid  (core_valid),
        .outstanding (outstanding),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: phase 0 idle, 1 streaming, 2 waiting for reads, 3 finished.
    int            m_phase;
    int            m_out;
    longint        m_rem;
    logic          m_wen;
    logic [DW-1:0] m_data;
    logic          m_cfg;
    bit            m_acc;

    int            n_wen;
    int            n_done;
    logic [DW-1:0] q_exp[$];
    logic [DW-1:0] q_got[$];
    bit            seq_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void mdl_reset();
        m_phase = 0;
        m_out   = 0;
        m_rem   = 0;
        m_wen   = 1'b0;
        m_data  = '0;
        m_cfg   = 1'b0;
        m_acc   = 1'b0;
    endfunction

    function automatic void mdl_edge();
        bit acc;
        bit rd;
        int prev_out;
        m_acc = 1'b0;
        if (!clk_en) return;
        if (flush) begin
            m_phase = 0;
            m_out   = 0;
            m_rem   = 0;
            m_wen   = 1'b0;
            m_cfg   = 1'b0;
            return;
        end
        prev_out = m_out;
        acc   = (m_phase == 1) && (m_out < int'(depth)) && src_valid;
        rd    = core_ren && core_valid && (m_out > 0);
        m_out = m_out + (acc ? 1 : 0) - (rd ? 1 : 0);
        m_wen = acc;
        if (acc) begin
            m_data = src_data;
            q_exp.push_back(src_data);
        end
        m_cfg = (m_phase == 0) && start && (depth == 0);
        m_acc = acc;
        case (m_phase)
            0: if (start && depth != 0) begin
                   if (num_words == 0) m_phase = 3;
                   else begin
                       m_phase = 1;
                       m_rem   = longint'(num_words);
                   end
               end
            1: if (acc) begin
                   m_rem--;
                   if (m_rem == 0) m_phase = 2;
               end
            2: if (prev_out == 0) m_phase = 3;
            default: m_phase = 0;
        endcase
    endfunction

    // One clock: inputs already set after a falling edge.
    task automatic cycle();
        logic          w;
        logic          d;
        logic [DW-1:0] dv;
        #1;
        chk("src_ready",   src_ready,   (clk_en && m_phase == 1 && m_out < int'(depth)));
        chk("wen_out",     wen_out,     m_wen);
        chk("data_out",    data_out,    m_data);
        chk("outstanding", outstanding, m_out);
        chk("busy",        busy,        (m_phase != 0));
        chk("done",        done,        (m_phase == 3));
        chk("cfg_err",     cfg_err,     m_cfg);
        chk("out_le_depth", (outstanding <= {1'b0, depth}), 1'b1);
        w  = wen_out;
        d  = done;
        dv = data_out;
        @(posedge clk);
        if (clk_en) begin
            if (w === 1'b1) begin
                n_wen++;
                q_got.push_back(dv);
            end
            if (d === 1'b1) n_done++;
        end
        mdl_edge();
        @(negedge clk);
        if (seq_data && m_acc) src_data = src_data + 1'b1;
    endtask

    task automatic setin(input bit v, input bit r, input bit cv, input bit en, input bit fl);
        src_valid  = v;
        core_ren   = r;
        core_valid = cv;
        clk_en     = en;
        flush      = fl;
    endtask

    task automatic begin_xfer(input int d, input longint nw);
        depth     = DPW'(d);
        num_words = CW'(nw);
        n_wen     = 0;
        n_done    = 0;
        q_exp.delete();
        q_got.delete();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic finish_xfer(input int budget);
        setin(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < budget && busy === 1'b1; i++) cycle();
        chk("xfer_timeout_busy", busy, 1'b0);
    endtask

    task automatic check_xfer(input longint nw);
        int n;
        chk("n_writes", n_wen, nw);
        chk("n_done", n_done, 1);
        chk("wr_count", q_got.size(), q_exp.size());
        n = (q_got.size() < q_exp.size()) ? q_got.size() : q_exp.size();
        for (int i = 0; i < n; i++) chk("wr_order", q_got[i], q_exp[i]);
    endtask

    task automatic check_reset_outputs();
        chk("rst_src_ready",   src_ready,   1'b0);
        chk("rst_wen_out",     wen_out,     1'b0);
        chk("rst_data_out",    data_out,    '0);
        chk("rst_outstanding", outstanding, '0);
        chk("rst_busy",        busy,        1'b0);
        chk("rst_done",        done,        1'b0);
        chk("rst_cfg_err",     cfg_err,     1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int nw;
        seq_data = 1'b0;
        reset    = 1'b1;
        start    = 1'b0;
        depth    = DPW'(4);
        num_words = '0;
        src_data = '0;
        setin(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check_reset_outputs();
        mdl_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // depth 4, 4 words, no reads: fills, stalls, then drains.
        seq_data = 1'b1;
        src_data = DW'(1);
        setin(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        begin_xfer(4, 4);
        for (int i = 0; i < 7; i++) cycle();
        chk("t1_out_full",   outstanding, 4);
        chk("t1_ready_low",  src_ready,   1'b0);
        chk("t1_writes",     n_wen,       4);
        finish_xfer(20);
        check_xfer(4);
        chk("t1_len", q_got.size(), 4);
        for (int i = 0; i < 4 && i < q_got.size(); i++) chk("t1_data", q_got[i], i + 1);

        // depth 2, 6 words, reads every cycle.
        src_data = DW'(16'h0010);
        setin(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        begin_xfer(2, 6);
        finish_xfer(60);
        check_xfer(6);

        // depth 2: fill to the limit, then overlap reads with accepts.
        setin(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        begin_xfer(2, 4);
        for (int i = 0; i < 3; i++) cycle();
        chk("t3_out_at_depth", outstanding, 2);
        chk("t3_ready_low",    src_ready,   1'b0);
        finish_xfer(40);
        check_xfer(4);

        // start with depth 0: error pulse, stays idle.
        setin(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        depth     = '0;
        num_words = CW'(5);
        start     = 1'b1;
        cycle();
        start = 1'b0;
        chk("t4_cfg_err",  cfg_err, 1'b1);
        chk("t4_idle",     busy,    1'b0);
        cycle();
        chk("t4_cfg_pulse", cfg_err, 1'b0);

        // start with zero words: done without writes.
        setin(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        begin_xfer(3, 0);
        for (int i = 0; i < 4; i++) cycle();
        check_xfer(0);

        // flush mid-stream at outstanding 3.
        begin_xfer(8, 10);
        for (int i = 0; i < 3; i++) cycle();
        chk("t5_out3", outstanding, 3);
        setin(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle();
        setin(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_flush_busy", busy,        1'b0);
        chk("t5_flush_out",  outstanding, '0);
        chk("t5_flush_wen",  wen_out,     1'b0);
        cycle();

        // asynchronous reset while draining.
        setin(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        begin_xfer(4, 2);
        for (int i = 0; i < 4; i++) cycle();
        chk("t5_in_drain", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs();
        mdl_reset();
        @(negedge clk);
        reset = 1'b0;
        setin(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();

        // clk_en low for three cycles mid-stream.
        src_data = DW'(16'h0100);
        setin(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        begin_xfer(8, 6);
        for (int i = 0; i < 2; i++) cycle();
        setin(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        chk("t6_frozen_out", outstanding, 2);
        chk("t6_no_ready",   src_ready,   1'b0);
        finish_xfer(40);
        check_xfer(6);

        // randomized transfers.
        seq_data = 1'b0;
        for (int t = 0; t < 25; t++) begin
            d  = 1 + int'($urandom % 5);
            nw = int'($urandom % 13);
            setin(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            src_data = DW'($urandom);
            begin_xfer(d, nw);
            for (int i = 0; i < 400 && busy === 1'b1; i++) begin
                src_valid  = ($urandom % 4) != 0;
                core_ren   = ($urandom % 2) != 0;
                core_valid = ($urandom % 3) != 0;
                clk_en     = ($urandom % 8) != 0;
                src_data   = DW'($urandom);
                start      = (m_phase != 0) && (($urandom % 8) == 0);
                cycle();
            end
            start = 1'b0;
            chk("rand_timeout_busy", busy, 1'b0);
            check_xfer(nw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
